// File: rtl/rca_share_sched.sv
// Time-shared N-bit ripple-carry slice: a W = N*CHUNKS bit add is done over CHUNKS
// cycles, LSB chunk first, with round-robin arbitration among REQ requesters.
module rca_share_sched #(
    parameter int N      = 4,
    parameter int CHUNKS = 4,
    parameter int REQ    = 2,
    localparam int W     = N * CHUNKS,
    localparam int IDW   = ($clog2(REQ) > 1) ? $clog2(REQ) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [REQ-1:0]     req_valid,
    output logic [REQ-1:0]     req_ready,
    input  logic [REQ*W-1:0]   req_a,
    input  logic [REQ*W-1:0]   req_b,
    input  logic [REQ-1:0]     req_cin,
    output logic               resp_valid,
    input  logic               resp_ready,
    output logic [IDW-1:0]     resp_id,
    output logic [W-1:0]       resp_sum,
    output logic               resp_cout,
    output logic               busy
);
    // Handshakes: a transfer happens on a rising edge where valid and ready are both
    // high; resp_* stay stable while resp_valid is high and resp_ready is low.

    localparam int CW = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t         state, state_next;
    logic [CW-1:0]  cnt;
    logic           carry;
    logic           cout_reg;
    logic [W-1:0]   a_reg, b_reg, sum_reg;
    logic [IDW-1:0] id_reg, last_grant;
    logic [IDW-1:0] grant_id, hi_id, lo_id;
    logic           grant_any, hi_any, lo_any;
    logic           accept, last_chunk;
    logic [N-1:0]   slice_sum;
    logic           slice_cout;

    // Round-robin: prefer the lowest valid index above last_grant, else wrap to the lowest.
    always_comb begin
        hi_any = 1'b0;
        hi_id  = '0;
        lo_any = 1'b0;
        lo_id  = '0;
        for (int i = REQ - 1; i >= 0; i--) begin
            if (req_valid[i]) begin
                if (IDW'(i) > last_grant) begin
                    hi_any = 1'b1;
                    hi_id  = IDW'(i);
                end
                lo_any = 1'b1;
                lo_id  = IDW'(i);
            end
        end
        grant_any = hi_any | lo_any;
        grant_id  = hi_any ? hi_id : lo_id;
    end

    assign accept     = (state == IDLE) && grant_any;
    assign last_chunk = (cnt == CW'(CHUNKS - 1));
    assign {slice_cout, slice_sum} = {1'b0, a_reg[cnt*N +: N]} + {1'b0, b_reg[cnt*N +: N]}
                                   + {{N{1'b0}}, carry};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = RUN;
            RUN:     if (last_chunk) state_next = DONE;
            DONE:    if (resp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        req_ready = '0;
        if (state == IDLE && !rst && grant_any) req_ready[grant_id] = 1'b1;
        resp_valid = (state == DONE);
        busy       = (state != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt        <= '0;
            carry      <= 1'b0;
            cout_reg   <= 1'b0;
            a_reg      <= '0;
            b_reg      <= '0;
            sum_reg    <= '0;
            id_reg     <= '0;
            last_grant <= IDW'(REQ - 1);
        end else begin
            if (accept) begin
                a_reg      <= req_a[grant_id*W +: W];
                b_reg      <= req_b[grant_id*W +: W];
                carry      <= req_cin[grant_id];
                id_reg     <= grant_id;
                last_grant <= grant_id;
                cnt        <= '0;
            end else if (state == RUN) begin
                sum_reg[cnt*N +: N] <= slice_sum;
                carry               <= slice_cout;
                cnt                 <= cnt + CW'(1);
                if (last_chunk) cout_reg <= slice_cout;
            end
        end
    end

    assign resp_sum  = sum_reg;
    assign resp_cout = cout_reg;
    assign resp_id   = id_reg;

endmodule

// File: tb/tb_rca_share_sched.sv
// Randomised and directed bench for rca_share_sched with a queue-based scoreboard and
// a transaction-level model of arbitration, latency and arithmetic.
module tb_rca_share_sched;
    localparam int N      = 4;
    localparam int CHUNKS = 4;
    localparam int REQ    = 2;
    localparam int W      = N * CHUNKS;
    localparam int IDW    = 1;
    localparam int EW     = IDW + 1 + W;

    logic             clk = 1'b0;
    logic             rst;
    logic [REQ-1:0]   req_valid;
    logic [REQ-1:0]   req_ready;
    logic [REQ*W-1:0] req_a;
    logic [REQ*W-1:0] req_b;
    logic [REQ-1:0]   req_cin;
    logic             resp_valid;
    logic             resp_ready;
    logic [IDW-1:0]   resp_id;
    logic [W-1:0]     resp_sum;
    logic             resp_cout;
    logic             busy;

    int vectors     = 0;
    int miscompares = 0;

    logic [EW-1:0] exp_q[$];
    int            id_log[$];
    int            resp_seen = 0;

    // model state
    int last_g   = REQ - 1;
    bit busy_exp = 1'b0;
    int cnt_m    = 0;

    rca_share_sched #(.N(N), .CHUNKS(CHUNKS), .REQ(REQ)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_cin(req_cin), .resp_valid(resp_valid),
        .resp_ready(resp_ready), .resp_id(resp_id), .resp_sum(resp_sum),
        .resp_cout(resp_cout), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic int rr_pick(input logic [REQ-1:0] v, input int last);
        for (int k = 1; k <= REQ; k++) begin
            int idx;
            idx = (last + k) % REQ;
            if (v[idx]) return idx;
        end
        return -1;
    endfunction

    // Request side: expected grant, busy/resp_valid timing, and pushing expected results.
    always @(negedge clk) begin
        if (rst) begin
            last_g   = REQ - 1;
            busy_exp = 1'b0;
            cnt_m    = 0;
            exp_q.delete();
            chk("ready_in_reset", 64'(req_ready), 64'(0));
        end else begin
            int            g;
            logic [REQ-1:0] er;
            logic [W:0]     full;
            chk("busy", 64'(busy), 64'(busy_exp));
            chk("resp_valid", 64'(resp_valid), 64'(busy_exp && cnt_m == 0));
            g  = busy_exp ? -1 : rr_pick(req_valid, last_g);
            er = '0;
            if (g >= 0) er[g] = 1'b1;
            chk("req_ready", 64'(req_ready), 64'(er));
            if (g >= 0) begin
                full = {1'b0, req_a[g*W +: W]} + {1'b0, req_b[g*W +: W]} + (W+1)'(req_cin[g]);
                exp_q.push_back({IDW'(g), full});
                last_g   = g;
                busy_exp = 1'b1;
                cnt_m    = CHUNKS;
            end else if (busy_exp) begin
                if (cnt_m > 0) cnt_m--;
                else if (resp_ready) busy_exp = 1'b0;
            end
        end
    end

    // Response side: compare every presented result against the scoreboard head.
    always @(negedge clk) begin
        if (!rst && resp_valid) begin
            if (exp_q.size() == 0) begin
                chk("resp_unexpected", 64'(1), 64'(0));
            end else begin
                logic [EW-1:0] e;
                e = exp_q[0];
                chk("resp_id", 64'(resp_id), 64'(e[W+IDW:W+1]));
                chk("resp_cout", 64'(resp_cout), 64'(e[W]));
                chk("resp_sum", 64'(resp_sum), 64'(e[W-1:0]));
                if (resp_ready) begin
                    void'(exp_q.pop_front());
                    id_log.push_back(int'(e[W+IDW:W+1]));
                    resp_seen++;
                end
            end
        end
    end

    task automatic issue(input int i, input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
        bit got;
        got = 1'b0;
        req_a[i*W +: W] = a;
        req_b[i*W +: W] = b;
        req_cin[i]      = c;
        req_valid[i]    = 1'b1;
        for (int t = 0; t < 50 && !got; t++) begin
            @(negedge clk);
            if (req_ready[i]) got = 1'b1;
        end
        if (!got) chk("accept_timeout", 64'(0), 64'(1));
        @(posedge clk);
        #1 req_valid[i] = 1'b0;
    endtask

    task automatic drain();
        bit done;
        done = 1'b0;
        for (int t = 0; t < 300 && !done; t++) begin
            @(negedge clk);
            if (!busy && !resp_valid && exp_q.size() == 0) done = 1'b1;
        end
        if (!done) chk("drain_timeout", 64'(0), 64'(1));
    endtask

    task automatic wait_resps(input int target);
        for (int t = 0; t < 200 && resp_seen < target; t++) @(negedge clk);
        if (resp_seen < target) chk("resp_timeout", 64'(resp_seen), 64'(target));
    endtask

    initial begin
        rst        = 1'b1;
        req_valid  = '0;
        req_a      = '0;
        req_b      = '0;
        req_cin    = '0;
        resp_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_sum", 64'(resp_sum), 64'(0));
        chk("rst_cout", 64'(resp_cout), 64'(0));
        chk("rst_id", 64'(resp_id), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        rst = 1'b0;

        // single request and full-ripple cases
        issue(0, 16'h1234, 16'h0FFF, 1'b0);
        drain();
        chk("t1_sum", 64'(resp_sum), 64'h2233);
        chk("t1_cout", 64'(resp_cout), 64'(0));
        chk("t1_id", 64'(resp_id), 64'(0));
        issue(1, 16'hFFFF, 16'h0000, 1'b1);
        drain();
        chk("t2a_sum", 64'(resp_sum), 64'h0000);
        chk("t2a_cout", 64'(resp_cout), 64'(1));
        chk("t2a_id", 64'(resp_id), 64'(1));
        issue(0, 16'h8000, 16'h8000, 1'b0);
        drain();
        chk("t2b_sum", 64'(resp_sum), 64'h0000);
        chk("t2b_cout", 64'(resp_cout), 64'(1));

        // contention from reset release
        @(posedge clk);
        #1 rst = 1'b1;
        req_a = {16'd2, 16'd1};
        req_b = {16'd2, 16'd1};
        req_cin = '0;
        req_valid = 2'b11;
        @(posedge clk);
        #1 rst = 1'b0;
        id_log.delete();
        wait_resps(resp_seen + 4);
        @(posedge clk);
        #1 req_valid = '0;
        drain();
        for (int k = 0; k < 4; k++)
            chk("rotation_id", 64'(id_log.size() > k ? id_log[k] : -1), 64'(k % 2));

        // backpressure in DONE with req0 still valid
        resp_ready = 1'b0;
        req_a[W-1:0] = 16'h0ABC;
        req_b[W-1:0] = 16'h0101;
        req_valid[0] = 1'b1;
        for (int t = 0; t < 50 && !resp_valid; t++) @(negedge clk);
        chk("bp_reached_done", 64'(resp_valid), 64'(1));
        repeat (3) @(posedge clk);
        #1 resp_ready = 1'b1;
        wait_resps(resp_seen + 1);
        for (int t = 0; t < 20 && !req_ready[0]; t++) @(negedge clk);
        @(posedge clk);
        #1 req_valid = '0;
        drain();

        // asynchronous reset during chunk 2
        issue(0, 16'h1111, 16'h2222, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
        req_a = {16'd7, 16'd5};
        req_b = {16'd8, 16'd6};
        req_valid = 2'b11;
        #1;
        chk("arst_sum", 64'(resp_sum), 64'(0));
        chk("arst_cout", 64'(resp_cout), 64'(0));
        chk("arst_id", 64'(resp_id), 64'(0));
        chk("arst_valid", 64'(resp_valid), 64'(0));
        chk("arst_busy", 64'(busy), 64'(0));
        chk("arst_ready", 64'(req_ready), 64'(0));
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("post_rst_grant", 64'(req_ready), 64'(2'b01));
        @(posedge clk);
        #1 req_valid = '0;
        drain();

        // operands changed after acceptance
        issue(0, 16'h00F0, 16'h0F0F, 1'b1);
        req_a[W-1:0] = 16'hFFFF;
        req_b[W-1:0] = 16'h1234;
        drain();
        chk("latched_sum", 64'(resp_sum), 64'h1000);
        chk("latched_cout", 64'(resp_cout), 64'(0));

        // random traffic with random backpressure
        for (int c = 0; c < 400; c++) begin
            @(posedge clk);
            #1;
            req_valid = REQ'($urandom_range(0, 3));
            for (int i = 0; i < REQ; i++) begin
                req_a[i*W +: W] = W'($urandom());
                req_b[i*W +: W] = W'($urandom());
                req_cin[i]      = 1'($urandom_range(0, 1));
            end
            resp_ready = ($urandom_range(0, 3) != 0);
        end
        @(posedge clk);
        #1 req_valid = '0;
        resp_ready = 1'b1;
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
